// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - DMI request/response types and encodings shared with the debug module
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    localparam logic [1:0] DTM_SUCCESS = 2'h0;
    localparam logic [1:0] DTM_ERR     = 2'h2;
    localparam logic [1:0] DTM_BUSY    = 2'h3;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/wb_dmi_master_pkg.sv
// rtl/wb_dmi_master_pkg.sv - state encoding and CTRL register layout of the Wishbone-to-DMI bridge
package wb_dmi_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_ACK  = 2'd3
    } state_e;

    // Word address (adr[9:2]) of the bridge's own control register.
    localparam logic [7:0] CTRL_WORD_ADDR = 8'h80;

    // CTRL write bit: pulse dmi_rst_n.
    localparam int CTRL_DMIRESET_BIT = 0;
    // CTRL read bits.
    localparam int CTRL_ERR_STICKY_BIT     = 0;
    localparam int CTRL_TIMEOUT_STICKY_BIT = 1;

endpackage

// File: rtl/wb_dmi_master_if.sv
// rtl/wb_dmi_master_if.sv - Wishbone pipelined bus interface with master/slave modports
// Signals: cyc, stb, we, adr[31:0], sel[3:0], dat_m[31:0] from master;
//          dat_s[31:0], ack, err, stall from slave.
interface wb_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_m;
    logic [31:0] dat_s;
    logic        ack;
    logic        err;
    logic        stall;

    modport master (
        output cyc, stb, we, adr, sel, dat_m,
        input  dat_s, ack, err, stall
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_m,
        output dat_s, ack, err, stall
    );
endinterface

// File: rtl/wb_dmi_master_dmi_rst_pulse.sv
// rtl/wb_dmi_master_dmi_rst_pulse.sv - fixed-length active-low dmi_rst_n pulse generator
// Ports: clk, rst_n (async, active low), trigger (1-cycle request),
//        dmi_rst_n (registered; low for PulseCycles cycles after trigger, low in reset).
module dmi_rst_pulse #(
    parameter int unsigned PulseCycles = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trigger,
    output logic dmi_rst_n
);
    localparam int unsigned CntW = (PulseCycles > 2) ? $clog2(PulseCycles) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rst_n_q, rst_n_d;

    // The trigger cycle itself drives the output low, so the counter only
    // has to cover the remaining PulseCycles-1 cycles.
    always_comb begin
        cnt_d   = cnt_q;
        rst_n_d = 1'b1;
        if (trigger) begin
            cnt_d   = CntW'(PulseCycles - 1);
            rst_n_d = 1'b0;
        end else if (cnt_q != '0) begin
            cnt_d   = cnt_q - CntW'(1);
            rst_n_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            rst_n_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rst_n_q <= rst_n_d;
        end
    end

    assign dmi_rst_n = rst_n_q;
endmodule

// File: rtl/wb_dmi_master.sv
// rtl/wb_dmi_master.sv - Wishbone slave to DMI initiator bridge with timeout and CTRL register
// Ports: clk, rst_n (async, active low); wbs (Wishbone pipelined slave);
//        dmi_rst_n, dmi_req_valid/ready, dmi_req, dmi_resp_valid/ready, dmi_resp (DMI initiator).
module wb_dmi_master
    import wb_dmi_master_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_if.slave           wbs,
    output logic          dmi_rst_n,
    output logic          dmi_req_valid,
    input  logic          dmi_req_ready,
    output dm::dmi_req_t  dmi_req,
    input  logic          dmi_resp_valid,
    output logic          dmi_resp_ready,
    input  dm::dmi_resp_t dmi_resp
);
    localparam int unsigned    CntW    = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    state_e        state_q, state_d;
    logic          req_valid_q, req_valid_d;
    logic          resp_ready_q, resp_ready_d;
    dm::dmi_req_t  req_q, req_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [31:0]   dat_s_q, dat_s_d;
    logic          err_sticky_q, err_sticky_d;
    logic          timeout_sticky_q, timeout_sticky_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic          is_read_q, is_read_d;
    logic          cyc_lost_q, cyc_lost_d;
    logic          pulse_trigger;

    logic [7:0] word_adr;
    logic       abandoned;
    logic       timed_out;
    logic       unused_adr;

    assign word_adr   = wbs.adr[9:2];
    assign unused_adr = ^{wbs.adr[31:10], wbs.adr[1:0]};
    // Once the master drops cyc the DMI side still finishes, but nobody is
    // left to receive ack/err.
    assign abandoned  = cyc_lost_q | ~wbs.cyc;
    assign timed_out  = (cnt_q == CntLast);

    always_comb begin
        state_d          = state_q;
        req_valid_d      = req_valid_q;
        resp_ready_d     = resp_ready_q;
        req_d            = req_q;
        ack_d            = 1'b0;
        err_d            = 1'b0;
        dat_s_d          = '0;
        err_sticky_d     = err_sticky_q;
        timeout_sticky_d = timeout_sticky_q;
        cnt_d            = cnt_q;
        is_read_d        = is_read_q;
        cyc_lost_d       = cyc_lost_q;
        pulse_trigger    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (wbs.cyc && wbs.stb) begin
                    cyc_lost_d = 1'b0;
                    if (!word_adr[7]) begin
                        if (wbs.we && (wbs.sel != 4'hF)) begin
                            // DMI registers are 32-bit only; partial writes are refused.
                            state_d      = ST_ACK;
                            err_d        = 1'b1;
                            err_sticky_d = 1'b1;
                        end else begin
                            state_d      = ST_REQ;
                            req_valid_d  = 1'b1;
                            cnt_d        = '0;
                            is_read_d    = ~wbs.we;
                            req_d.addr   = word_adr[6:0];
                            if (wbs.we) begin
                                req_d.op   = dm::DTM_WRITE;
                                req_d.data = wbs.dat_m;
                            end else begin
                                req_d.op   = dm::DTM_READ;
                                req_d.data = '0;
                            end
                        end
                    end else if (word_adr == CTRL_WORD_ADDR) begin
                        state_d = ST_ACK;
                        ack_d   = 1'b1;
                        if (wbs.we) begin
                            err_sticky_d     = 1'b0;
                            timeout_sticky_d = 1'b0;
                            pulse_trigger    = wbs.dat_m[CTRL_DMIRESET_BIT];
                        end else begin
                            dat_s_d[CTRL_ERR_STICKY_BIT]     = err_sticky_q;
                            dat_s_d[CTRL_TIMEOUT_STICKY_BIT] = timeout_sticky_q;
                        end
                    end else begin
                        state_d      = ST_ACK;
                        err_d        = 1'b1;
                        err_sticky_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                cnt_d      = cnt_q + CntW'(1);
                cyc_lost_d = abandoned;
                if (dmi_req_ready) begin
                    req_valid_d  = 1'b0;
                    resp_ready_d = 1'b1;
                    state_d      = ST_RESP;
                end else if (timed_out) begin
                    state_d          = ST_ACK;
                    req_valid_d      = 1'b0;
                    err_d            = ~abandoned;
                    timeout_sticky_d = 1'b1;
                    pulse_trigger    = 1'b1;
                end
            end
            ST_RESP: begin
                cnt_d      = cnt_q + CntW'(1);
                cyc_lost_d = abandoned;
                if (dmi_resp_valid) begin
                    resp_ready_d = 1'b0;
                    state_d      = ST_ACK;
                    if (is_read_q) dat_s_d = dmi_resp.data;
                    if (dmi_resp.resp == dm::DTM_SUCCESS) begin
                        ack_d = ~abandoned;
                    end else begin
                        err_d        = ~abandoned;
                        err_sticky_d = 1'b1;
                    end
                end else if (timed_out) begin
                    // A stuck DM is reset so the next access starts clean.
                    state_d          = ST_ACK;
                    resp_ready_d     = 1'b0;
                    err_d            = ~abandoned;
                    timeout_sticky_d = 1'b1;
                    pulse_trigger    = 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            req_valid_q      <= 1'b0;
            resp_ready_q     <= 1'b0;
            req_q            <= '0;
            ack_q            <= 1'b0;
            err_q            <= 1'b0;
            dat_s_q          <= '0;
            err_sticky_q     <= 1'b0;
            timeout_sticky_q <= 1'b0;
            cnt_q            <= '0;
            is_read_q        <= 1'b0;
            cyc_lost_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            req_valid_q      <= req_valid_d;
            resp_ready_q     <= resp_ready_d;
            req_q            <= req_d;
            ack_q            <= ack_d;
            err_q            <= err_d;
            dat_s_q          <= dat_s_d;
            err_sticky_q     <= err_sticky_d;
            timeout_sticky_q <= timeout_sticky_d;
            cnt_q            <= cnt_d;
            is_read_q        <= is_read_d;
            cyc_lost_q       <= cyc_lost_d;
        end
    end

    dmi_rst_pulse #(
        .PulseCycles (2)
    ) u_dmi_rst_pulse (
        .clk       (clk),
        .rst_n     (rst_n),
        .trigger   (pulse_trigger),
        .dmi_rst_n (dmi_rst_n)
    );

    assign wbs.stall      = (state_q != ST_IDLE);
    assign wbs.ack        = ack_q;
    assign wbs.err        = err_q;
    assign wbs.dat_s      = dat_s_q;
    assign dmi_req_valid  = req_valid_q;
    assign dmi_resp_ready = resp_ready_q;
    assign dmi_req        = req_q;
endmodule

// File: doc/wb_dmi_master.md
# wb_dmi_master

Wishbone-slave-to-DMI bridge acting as the initiator (DTM side) of the RocketChip-compatible DMI request/response channel. A host-side Wishbone master (UART/SPI debug bridge, boot CPU) issues single 32-bit reads and writes that are translated into `dm::dmi_req_t` transactions toward a debug module's DMI port, with the `dm::dmi_resp_t` result returned as Wishbone ack/err. It sits in the same system as the Wishbone debug module and drives that module's `dmi_*` ports.

## Interface
- `TimeoutCycles`, default 1024: cycles a transaction may spend in REQ plus RESP before it is aborted.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous reset, active low.
- `wbs`  `wb_if.slave`  —  Wishbone pipelined slave. Uses `cyc`, `stb`, `we`, `adr`, `sel`, `dat_m`; drives `dat_s`, `ack`, `err`, `stall`.
- `dmi_rst_n`  out  1  DMI reset to the DM, active low.
- `dmi_req_valid`  out  1  request valid.
- `dmi_req_ready`  in  1  request accepted.
- `dmi_req`  out  `dm::dmi_req_t`  addr[6:0], op, data[31:0].
- `dmi_resp_valid`  in  1  response valid.
- `dmi_resp_ready`  out  1  response consumed.
- `dmi_resp`  in  `dm::dmi_resp_t`  data[31:0], resp[1:0].

## Operation
Address map uses word address `wbs.adr[9:2]`:
- 0x00–0x7F: DMI register `adr[8:2]`.
- 0x80: CTRL. A write with bit0 set pulses `dmi_rst_n`. Reads return {30'b0, timeout_sticky, err_sticky}. Any CTRL write clears both sticky bits.
- Other offsets: err, with no DMI activity.

FSM states:
- IDLE: `stall` = 0. Accept on `cyc & stb`.
  - DMI write with `sel` != 4'hF: error path, no request issued.
  - DMI read: op = DTM_READ (1), data = 0.
  - DMI write: op = DTM_WRITE (2), data = `dat_m`.
  - CTRL and error paths go straight to ACK.
- REQ: `dmi_req_valid` = 1 and `dmi_req` held stable. On `dmi_req_ready`, go to RESP.
- RESP: `dmi_resp_ready` = 1. On `dmi_resp_valid`, capture data and resp, then go to ACK.
- ACK: for one cycle, pulse `ack` if resp == DTM_SUCCESS (0) or for a CTRL access. Otherwise pulse `err` and set `err_sticky`. `dat_s` = captured data for reads, 0 for writes. Return to IDLE.

Other rules:
- `stall` = 1 in every state except IDLE. Only one transaction is outstanding at a time.
- Timeout: a counter runs in REQ and RESP and clears on entry to REQ. When it reaches `TimeoutCycles`:
  - abort to ACK with `err`, and set `timeout_sticky`;
  - drive `dmi_rst_n` low for 2 cycles;
  - drop `dmi_req_valid` and `dmi_resp_ready`.
- `cyc` deasserted mid-transaction: the DMI transaction still completes, and the ACK-state `ack`/`err` is suppressed.
- A `dmi_resp_valid` arriving in IDLE or REQ is ignored, since `dmi_resp_ready` = 0.

## Timing
- Reset values:
  - `dmi_rst_n` = 0, going to 1 in the first clock after `rst_n` releases;
  - `dmi_req_valid`, `dmi_resp_ready`, `ack`, `err`, `stall` = 0;
  - `dmi_req` = 0 (op DTM_NOP); `dat_s` = 0; both sticky bits = 0; state IDLE.
- All outputs are registered except `stall`, which is decoded from state.
- Minimum DMI latency: accept at T, `dmi_req_valid` at T+1 (ready in the same cycle), response at T+2, `ack` at T+3.
- CTRL and error paths: `ack`/`err` at T+1.
- `ack` and `err` are never high together and are each high for exactly one cycle.
- `rst_n` asserted mid-operation: everything returns to reset values immediately. No response is generated for the aborted cycle.
- A CTRL dmireset pulse holds `dmi_rst_n` low for 2 cycles starting at T+1. It overlaps the ack cycle.

## Structure
- DMI types and op/resp encodings come from the existing `dm` package.
- New `wb_dmi_master_pkg` holds:
  - the state enum (IDLE, REQ, RESP, ACK);
  - `CTRL_WORD_ADDR` = 8'h80;
  - the CTRL bit positions.
- One natural sub-module: `dmi_rst_pulse`. It is a small counter generating the 2-cycle `dmi_rst_n` low pulse, triggered by either CTRL writes or timeout.
- Everything else stays in a single module.

## Test plan
- Read DMI 0x11 (dmstatus); DM responds at T+2 with data 0x00400C82, resp 0 → `ack` at T+3, `dat_s` = 0x00400C82.
- Write 0x80000001 to DMI 0x10 with `dmi_req_ready` held low for 5 cycles → `dmi_req` stable throughout, op = 2, `ack` after ready plus response, `stall` high for the whole span.
- DM returns resp 3 (busy) on a write → `err` pulse, CTRL read returns 0x1, a CTRL write of 0 then reads 0x0.
- DM never responds, TimeoutCycles = 16 → `err` 16 cycles after REQ entry, `dmi_rst_n` low 2 cycles, CTRL reads 0x2.
- Write with `sel` = 4'h3 to a DMI address → `err` at T+1, `dmi_req_valid` never asserted.
- `cyc` dropped during RESP → DMI handshake completes, no `ack`/`err`, next access proceeds normally; `rst_n` pulsed during REQ → all outputs at reset values.
